// File: rtl/seq_calc.sv
// seq_calc: parametrised sequential two's-complement calculator with a shift-add multiplier.
// Define SEQ_CALC_DIV_EN to build the restoring divider for op 011; otherwise op 011 reports an illegal op.
module seq_calc #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             err_clr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] r_o,
    output logic             ovf_o,
    output logic             err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
`ifdef SEQ_CALC_DIV_EN
    localparam logic [1:0] S_DIV  = 2'd2;
`endif
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]         rstSync_q;
    logic               runEn;

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   opA_q, opA_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   mulAddend;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulStep;

`ifdef SEQ_CALC_DIV_EN
    logic [WIDTH-1:0]   magB;
    logic [WIDTH:0]     divShift;
    logic               divGeq;
    logic [WIDTH-1:0]   divRem;
    logic [2*WIDTH-1:0] divStep;
    logic [WIDTH-1:0]   divQuo;
`endif

    logic               resNeg;
    logic [2*WIDTH-1:0] prodSigned;
    logic [WIDTH-1:0]   addRes;
    logic [WIDTH-1:0]   subRes;
    logic [WIDTH-1:0]   accRes;
    logic [WIDTH-1:0]   resVal;
    logic               resOvf;
    logic               finishing;

    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Reset asserts immediately but releases into the FSM two clock edges later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign runEn = rstSync_q[1];

    // One iteration of the shift-add multiplier: accumulate into the upper half, shift right.
    always_comb begin
        magA      = absVal(opA_q);
        mulAddend = prod_q[0] ? magA : '0;
        mulSum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mulAddend};
        mulStep   = {mulSum, prod_q[WIDTH-1:1]};
    end

`ifdef SEQ_CALC_DIV_EN
    // One restoring-divide iteration; prod holds {remainder, dividend/quotient}.
    always_comb begin
        magB     = absVal(opB_q);
        divShift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        divGeq   = divShift >= {1'b0, magB};
        divRem   = divGeq ? (divShift[WIDTH-1:0] - magB) : divShift[WIDTH-1:0];
        divStep  = {divRem, prod_q[WIDTH-2:0], divGeq};
        divQuo   = prod_q[WIDTH-1:0];
    end
`endif

    always_comb begin
        resNeg     = opA_q[MSB] ^ opB_q[MSB];
        addRes     = opA_q + opB_q;
        subRes     = opA_q - opB_q;
        accRes     = r_q + opA_q;
        prodSigned = resNeg ? -prod_q : prod_q;
        resVal     = '0;
        resOvf     = 1'b0;
        case (op_q)
            OP_ADD: begin
                resVal = addRes;
                resOvf = (opA_q[MSB] == opB_q[MSB]) && (addRes[MSB] != opA_q[MSB]);
            end
            OP_SUB: begin
                resVal = subRes;
                resOvf = (opA_q[MSB] != opB_q[MSB]) && (subRes[MSB] != opA_q[MSB]);
            end
            OP_MUL: begin
                // In range only if the upper WIDTH+1 bits are a pure sign extension.
                resVal = prodSigned[WIDTH-1:0];
                resOvf = !((&prodSigned[2*WIDTH-1:WIDTH-1]) || !(|prodSigned[2*WIDTH-1:WIDTH-1]));
            end
            OP_DIV: begin
`ifdef SEQ_CALC_DIV_EN
                if (opB_q == '0) begin
                    resVal = '0;
                    resOvf = 1'b1;
                end else begin
                    resVal = resNeg ? -divQuo : divQuo;
                    resOvf = !resNeg && divQuo[MSB];
                end
`else
                resVal = '0;
                resOvf = 1'b1;
`endif
            end
            OP_AND: resVal = opA_q & opB_q;
            OP_OR:  resVal = opA_q | opB_q;
            OP_XOR: resVal = opA_q ^ opB_q;
            default: begin
                resVal = accRes;
                resOvf = (r_q[MSB] == opA_q[MSB]) && (accRes[MSB] != r_q[MSB]);
            end
        endcase
    end

    assign finishing = (state_q == S_FIN);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (runEn && start_i) begin
                    op_d  = op_i;
                    opA_d = a_i;
                    opB_d = b_i;
                    cnt_d = '0;
                    if (op_i == OP_MUL) begin
                        prod_d  = {{WIDTH{1'b0}}, absVal(b_i)};
                        state_d = S_MUL;
`ifdef SEQ_CALC_DIV_EN
                    end else if (op_i == OP_DIV) begin
                        prod_d  = {{WIDTH{1'b0}}, absVal(a_i)};
                        state_d = S_DIV;
`endif
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_MUL: begin
                prod_d = mulStep;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIN;
                end
            end
`ifdef SEQ_CALC_DIV_EN
            S_DIV: begin
                prod_d = divStep;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                r_d     = resVal;
                ovf_d   = resOvf;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new overflow always wins over a simultaneous clear request.
    always_comb begin
        if (finishing && resOvf) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign r_o    = r_q;
    assign ovf_o  = ovf_q;
    assign err_o  = err_q;

endmodule

// File: doc/seq_calc.md
# seq_calc

Parametrised sequential two's-complement calculator, successor to the 4-bit combinational calculator on the board top level. It latches signed operands and an opcode on a start strobe and runs single-cycle ALU operations or a multi-cycle shift-add multiply. It presents a registered result with per-operation overflow and a sticky error flag. It sits between the switch/key input logic and the per-digit two's-complement 7-segment decoders.

## Interface
- WIDTH, 4, operand/result width in bits, two's complement; legal range 2..16.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only while busy=0.
- op  in  3  opcode, latched with start.
- a  in  WIDTH  signed operand A, latched with start.
- b  in  WIDTH  signed operand B, latched with start.
- err_clr  in  1  synchronous clear of err.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when r/ovf update.
- r  out  WIDTH  registered signed result.
- ovf  out  1  overflow of the last completed operation.
- err  out  1  sticky OR of every ovf since the last clear.

## Operation
- Opcodes: 000 a+b; 001 a−b; 010 a×b (multi-cycle); 011 a÷b (see Configuration); 100 a&b; 101 a|b; 110 a^b; 111 accumulate r+a (b ignored).
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE: on start with op 010, latch operands and go to MUL. With op 011 and the divider compiled in, go to DIV. Any other start: compute, update r/ovf, go to FIN.
- MUL: take operand magnitudes, unsigned shift-add over WIDTH iterations into a 2·WIDTH product, then apply the sign (sign = a[MSB]^b[MSB]). After the last iteration, update r/ovf and go to FIN.
- DIV: restoring divide on magnitudes over WIDTH iterations, quotient truncated toward zero, sign applied at the end. After the last iteration, go to FIN.
- FIN: done=1 for this cycle only; returns to IDLE.
- r is always the low WIDTH bits of the exact result.
- Add and accumulate ovf: both operands have the same sign and the result sign differs.
- Subtract ovf: operand signs differ and the result sign differs from a.
- Multiply ovf: the signed product is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Logic ops: ovf=0.
- err: set on any cycle where ovf updates to 1. Cleared by err_clr when no set is occurring; a set wins over a simultaneous clear.
- start while busy=1 is ignored and not queued.

## Timing
- Reset values: r=0, ovf=0, err=0, busy=0, done=0, FSM=IDLE, internal operand/product registers 0.
- rst_n deassertion is released synchronously into the FSM. Reset mid-MUL or mid-DIV aborts the operation with no done.
- Single-cycle ops: start sampled at edge k → r/ovf valid and done=1 after edge k+1; busy=1 only during the cycle between k and k+1.
- Multiply/divide: start sampled at edge k → busy=1 from edge k through edge k+WIDTH+1; r/ovf update and done=1 after edge k+WIDTH+1.
- busy deasserts in the same cycle done is high, so start may be re-issued in the done cycle.
- r/ovf hold their values until the next completed operation.

## Configuration
- SEQ_CALC_DIV_EN defined: op 011 is signed divide.
  - b=0 → r=0, ovf=1.
  - a=−2^(WIDTH−1) and b=−1 → r=a, ovf=1.
- SEQ_CALC_DIV_EN undefined: no DIV state or divider logic; op 011 completes single-cycle with r=0, ovf=1 (illegal-op error).

## Test plan
- WIDTH=4, op=000, a=0111, b=0001 → after 1 cycle r=1000, ovf=1, err=1, done pulse; then err_clr → err=0.
- op=001, a=1000, b=0001 → r=0111, ovf=1; op=111 ×3 with a=0010 from r=0 → r=0110, ovf=0 each time.
- op=010, a=0011, b=1110 → busy for 5 cycles, r=1010 (−6), ovf=0; a=1000, b=1111 → r=1000, ovf=1.
- Assert start with op=000 mid-multiply → ignored, the multiply result is unaffected; rst_n low mid-multiply → r=0, busy=0, no done.
- With SEQ_CALC_DIV_EN: a=0111, b=1110 → r=1101 (−3); b=0000 → r=0000, ovf=1. Without the macro: op=011 → r=0000, ovf=1 after 1 cycle.
- WIDTH=8: op=010, a=0x0B, b=0xF5 (11×−11) → r=0x87 (−121), ovf=0, done after 9 cycles.
